// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with a variable-latency
// data-memory port. Produces the forwarding buses (exm_*, r3_*) and raises
// stall while a memory access is waiting for dm_ack.
//
// Handshake: dm_req is held high with dm_we/dm_addr/dm_wdata stable until the
// access completes, either by dm_ack in a requesting cycle or by the wait
// counter reaching TIMEOUT. dm_ack outside a request is ignored.
module mem_wb_pipe #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic [31:0]       ex_aluresult,
  input  logic [31:0]       ex_r2_dout,
  input  logic [4:0]        ex_rd,
  output logic [31:0]       exmaluresult,
  output logic [4:0]        exmrd,
  output logic              exmregwrite,
  output logic              exmmemread,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [4:0]        r3_addr,
  output logic [31:0]       r3_din,
  output logic              mwregwrite,
  output logic              stall,
  output logic              dm_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        err_q, err_d;

  // EX/MEM register fields
  logic        exm_valid_q, exm_valid_d;
  logic        exm_regwrite_q, exm_regwrite_d;
  logic        exm_memread_q, exm_memread_d;
  logic        exm_memwrite_q, exm_memwrite_d;
  logic        exm_memtoreg_q, exm_memtoreg_d;
  logic [31:0] exm_aluresult_q, exm_aluresult_d;
  logic [31:0] exm_r2_q, exm_r2_d;
  logic [4:0]  exm_rd_q, exm_rd_d;

  // MEM/WB register fields
  logic        mw_valid_q, mw_valid_d;
  logic        mw_regwrite_q, mw_regwrite_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic [31:0] mw_data_q, mw_data_d;

  logic        mem_op;
  logic        req;
  logic        timeout_hit;
  logic        done;
  logic        stall_int;
  logic [31:0] rdata_sel;

  // Request, completion and stall decode; reset forces the request low at once
  always_comb begin
    mem_op      = exm_valid_q & (exm_memread_q | exm_memwrite_q);
    req         = rst_n & mem_op;
    timeout_hit = (state_q == WAIT) & (count_q == TO_CNT) & ~dm_ack;
    done        = dm_ack | timeout_hit;
    stall_int   = req & ~done;
    rdata_sel   = (req & dm_ack) ? dm_rdata : 32'd0;
  end

  // Wait-state FSM: counts wait cycles, forces completion at TIMEOUT
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req & ~dm_ack) begin
          state_d = WAIT;
          count_d = 8'd1;
        end
      end
      WAIT: begin
        if (dm_ack) begin
          state_d = IDLE;
          count_d = 8'd0;
        end else if (count_q == TO_CNT) begin
          state_d = IDLE;
          count_d = 8'd0;
          err_d   = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // Pipeline advance: both stages hold while the memory access is stalled
  always_comb begin
    exm_valid_d     = exm_valid_q;
    exm_regwrite_d  = exm_regwrite_q;
    exm_memread_d   = exm_memread_q;
    exm_memwrite_d  = exm_memwrite_q;
    exm_memtoreg_d  = exm_memtoreg_q;
    exm_aluresult_d = exm_aluresult_q;
    exm_r2_d        = exm_r2_q;
    exm_rd_d        = exm_rd_q;
    mw_valid_d      = mw_valid_q;
    mw_regwrite_d   = mw_regwrite_q;
    mw_rd_d         = mw_rd_q;
    mw_data_d       = mw_data_q;
    if (!stall_int) begin
      exm_valid_d     = ex_valid;
      exm_regwrite_d  = ex_regwrite;
      exm_memread_d   = ex_memread;
      exm_memwrite_d  = ex_memwrite;
      exm_memtoreg_d  = ex_memtoreg;
      exm_aluresult_d = ex_aluresult;
      exm_r2_d        = ex_r2_dout;
      exm_rd_d        = ex_rd;
      mw_valid_d      = exm_valid_q;
      mw_regwrite_d   = exm_regwrite_q;
      mw_rd_d         = exm_rd_q;
      mw_data_d       = exm_memtoreg_q ? rdata_sel : exm_aluresult_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      count_q         <= 8'd0;
      err_q           <= 1'b0;
      exm_valid_q     <= 1'b0;
      exm_regwrite_q  <= 1'b0;
      exm_memread_q   <= 1'b0;
      exm_memwrite_q  <= 1'b0;
      exm_memtoreg_q  <= 1'b0;
      exm_aluresult_q <= 32'd0;
      exm_r2_q        <= 32'd0;
      exm_rd_q        <= 5'd0;
      mw_valid_q      <= 1'b0;
      mw_regwrite_q   <= 1'b0;
      mw_rd_q         <= 5'd0;
      mw_data_q       <= 32'd0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      err_q           <= err_d;
      exm_valid_q     <= exm_valid_d;
      exm_regwrite_q  <= exm_regwrite_d;
      exm_memread_q   <= exm_memread_d;
      exm_memwrite_q  <= exm_memwrite_d;
      exm_memtoreg_q  <= exm_memtoreg_d;
      exm_aluresult_q <= exm_aluresult_d;
      exm_r2_q        <= exm_r2_d;
      exm_rd_q        <= exm_rd_d;
      mw_valid_q      <= mw_valid_d;
      mw_regwrite_q   <= mw_regwrite_d;
      mw_rd_q         <= mw_rd_d;
      mw_data_q       <= mw_data_d;
    end
  end

  // Output drive: everything reads 0 while rst_n is low
  always_comb begin
    exmaluresult = rst_n ? exm_aluresult_q : 32'd0;
    exmrd        = rst_n ? exm_rd_q : 5'd0;
    exmregwrite  = rst_n & exm_valid_q & exm_regwrite_q;
    exmmemread   = rst_n & exm_valid_q & exm_memread_q;
    dm_req       = req;
    dm_we        = rst_n & exm_memwrite_q;
    dm_addr      = rst_n ? exm_aluresult_q[ADDR_W-1:0] : '0;
    dm_wdata     = rst_n ? exm_r2_q : 32'd0;
    r3_addr      = rst_n ? mw_rd_q : 5'd0;
    r3_din       = rst_n ? mw_data_q : 32'd0;
    mwregwrite   = rst_n & mw_valid_q & mw_regwrite_q;
    stall        = stall_int;
    dm_err       = rst_n & err_q;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and random instruction streams through mem_wb_pipe
// with a data-memory responder that inserts a chosen number of wait states.
module tb_mem_wb_pipe;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [31:0] ex_aluresult, ex_r2_dout;
  logic [4:0]  ex_rd;
  logic [31:0] exmaluresult;
  logic [4:0]  exmrd;
  logic        exmregwrite, exmmemread;
  logic        dm_req, dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [4:0]  r3_addr;
  logic [31:0] r3_din;
  logic        mwregwrite, stall, dm_err;

  mem_wb_pipe #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_aluresult(ex_aluresult), .ex_r2_dout(ex_r2_dout), .ex_rd(ex_rd),
    .exmaluresult(exmaluresult), .exmrd(exmrd), .exmregwrite(exmregwrite),
    .exmmemread(exmmemread), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .r3_addr(r3_addr), .r3_din(r3_din), .mwregwrite(mwregwrite),
    .stall(stall), .dm_err(dm_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];   // {rd, writeback data}
  logic [48:0] mem_q[$];   // {we, stall cycles, addr, wdata}
  int          waits_q[$];
  logic [31:0] rdata_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        force_ack;
  logic [4:0]  prev_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          rsp_cnt = 0;
  int          rsp_w = 0;
  logic        rsp_fresh = 1'b1;
  always begin
    @(negedge clk); #1;
    if (!rst_n || !dm_req) begin
      dm_ack    = force_ack;
      rsp_cnt   = 0;
      rsp_fresh = 1'b1;
    end else begin
      if (rsp_fresh) begin
        rsp_w    = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
        dm_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'd0;
        rsp_fresh = 1'b0;
      end
      dm_ack = (rsp_cnt == rsp_w) || force_ack;
      #1;
      if (stall) rsp_cnt++;
      else begin
        rsp_cnt   = 0;
        rsp_fresh = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int          run = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] last_r3 = 32'd0;
  logic [48:0] me;
  logic [36:0] we_e;
  always begin
    @(negedge clk); #3;
    if (!rst_n) begin
      run = 0;
      prev_stall = 1'b0;
    end else begin
      if (dm_req) begin
        if (stall) run++;
        else begin
          if (mem_q.size() == 0) check("mem_q_empty", mem_q.size(), 1);
          else begin
            me = mem_q.pop_front();
            check("dm_we", {31'd0, dm_we}, {31'd0, me[48]});
            check("stall_run", run, {24'd0, me[47:40]});
            check("dm_addr", {24'd0, dm_addr}, {24'd0, me[39:32]});
            check("dm_wdata", dm_wdata, me[31:0]);
          end
          run = 0;
        end
      end
      if (prev_stall) check("hold_r3_din", r3_din, last_r3);
      else last_r3 = r3_din;
      if (mwregwrite && !prev_stall) begin
        if (exp_q.size() == 0) check("wb_q_empty", exp_q.size(), 1);
        else begin
          we_e = exp_q.pop_front();
          check("r3_addr", {27'd0, r3_addr}, {27'd0, we_e[36:32]});
          check("r3_din", r3_din, we_e[31:0]);
        end
      end
      prev_stall = stall;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic set_bubble();
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
    ex_memtoreg = 0; ex_aluresult = 0; ex_r2_dout = 0; ex_rd = 0;
  endtask

  // Present one instruction (called at posedge+1), hold it until accepted.
  task automatic issue(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] r2,
                       input int waits, input logic [31:0] rdat);
    logic s;
    logic ok;
    int   runx;
    logic [31:0] wb;
    ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_memtoreg = mr; ex_aluresult = alu; ex_r2_dout = r2; ex_rd = rd;
    if (v && (mr || mw)) begin
      waits_q.push_back(waits);
      rdata_q.push_back(rdat);
      runx = (waits < 0 || waits > TO) ? TO : waits;
      mem_q.push_back({mw, 8'(runx), alu[7:0], r2});
    end
    if (v && rw) begin
      if (mr) wb = (waits >= 0 && waits <= TO) ? rdat : 32'd0;
      else    wb = alu;
      exp_q.push_back({rd, wb});
    end
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #3;
      s = stall;
      if (s) check("hold_exmrd", {27'd0, exmrd}, {27'd0, prev_rd});
      @(posedge clk); #1;
      if (!s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_stuck", {31'd0, stall}, 32'd0);
    prev_rd = rd;
    set_bubble();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0; force_ack = 0; dm_ack = 0; dm_rdata = 0; prev_rd = 0;
    set_bubble();
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); #3;
    check("rst_exmregwrite", {31'd0, exmregwrite}, 32'd0);
    check("rst_exmaluresult", exmaluresult, 32'd0);
    check("rst_r3_din", r3_din, 32'd0);
    check("rst_mwregwrite", {31'd0, mwregwrite}, 32'd0);
    check("rst_dm_err", {31'd0, dm_err}, 32'd0);
    sync();

    // ALU op: exm_* at cycle 1, r3_* at cycle 2
    issue(1, 1, 0, 0, 5'd5, 32'h1234, 32'd0, 0, 32'd0);
    @(negedge clk); #3;
    check("alu_exmrd", {27'd0, exmrd}, 32'd5);
    check("alu_exmregwrite", {31'd0, exmregwrite}, 32'd1);
    check("alu_exmaluresult", exmaluresult, 32'h1234);
    @(posedge clk); #1;
    @(negedge clk); #3;
    check("alu_r3_addr", {27'd0, r3_addr}, 32'd5);
    check("alu_r3_din", r3_din, 32'h1234);
    check("alu_mwregwrite", {31'd0, mwregwrite}, 32'd1);
    sync();

    // Zero-wait store
    issue(1, 0, 0, 1, 5'd0, 32'h10, 32'hCAFE, 0, 32'd0);
    @(negedge clk); #3;
    check("st_dm_req", {31'd0, dm_req}, 32'd1);
    check("st_dm_we", {31'd0, dm_we}, 32'd1);
    check("st_stall", {31'd0, stall}, 32'd0);
    repeat (3) sync();

    // Load with 3 wait states, followed by a dependent-free ALU op
    issue(1, 1, 1, 0, 5'd7, 32'h20, 32'd0, 3, 32'hDEADBEEF);
    @(negedge clk); #3;
    check("ld_exmmemread", {31'd0, exmmemread}, 32'd1);
    @(posedge clk); #1;
    issue(1, 1, 0, 0, 5'd8, 32'h88, 32'd0, 0, 32'd0);
    repeat (3) sync();

    // Ack coincident with the timeout: data wins, no error
    issue(1, 1, 1, 0, 5'd11, 32'h30, 32'd0, TO, 32'h5555AAAA);
    repeat (TO + 3) sync();
    @(negedge clk); #3;
    check("coinc_dm_err", {31'd0, dm_err}, 32'd0);
    sync();

    // Timeout: load never acked, next instruction still proceeds
    issue(1, 1, 1, 0, 5'd9, 32'h31, 32'd0, -1, 32'h11111111);
    issue(1, 1, 0, 0, 5'd10, 32'hA0A0, 32'd0, 0, 32'd0);
    repeat (TO + 3) sync();
    @(negedge clk); #3;
    check("to_dm_err", {31'd0, dm_err}, 32'd1);
    sync();

    // Reset in the 2nd wait cycle, late ack afterwards
    issue(1, 1, 1, 0, 5'd12, 32'h40, 32'd0, -1, 32'h22222222);
    sync();
    sync();
    rst_n = 0;
    exp_q.delete(); mem_q.delete(); waits_q.delete(); rdata_q.delete();
    prev_rd = 0;
    @(negedge clk); #3;
    check("rstw_dm_req", {31'd0, dm_req}, 32'd0);
    check("rstw_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    force_ack = 1;
    @(negedge clk); #3;
    check("rstw_mwregwrite", {31'd0, mwregwrite}, 32'd0);
    check("rstw_r3_din", r3_din, 32'd0);
    check("rstw_exmregwrite", {31'd0, exmregwrite}, 32'd0);
    check("rstw_dm_req2", {31'd0, dm_req}, 32'd0);
    check("rstw_dm_err", {31'd0, dm_err}, 32'd0);
    @(posedge clk); #1;
    force_ack = 0;
    @(negedge clk); #3;
    check("late_ack_mwregwrite", {31'd0, mwregwrite}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    sync();

    // Random mix of ALU ops, loads, stores and bubbles
    for (int k = 0; k < 40; k++) begin
      int          kind;
      int          w;
      logic [4:0]  rd;
      logic [31:0] a, d;
      kind = $urandom_range(0, 3);
      w    = $urandom_range(0, 6);
      rd   = 5'($urandom_range(0, 31));
      a    = $urandom;
      d    = $urandom;
      case (kind)
        0: issue(1, 1'($urandom_range(0, 1)), 0, 0, rd, a, d, 0, 32'd0);
        1: issue(1, 1'($urandom_range(0, 1)), 1, 0, rd, a, d, w, d ^ 32'h0F0F_0F0F);
        2: issue(1, 0, 0, 1, rd, a, d, w, 32'd0);
        default: issue(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
      endcase
    end
    repeat (20) sync();
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
